// File: rtl/ph_table_ctrl_if.sv
// ph_table_ctrl_if: request/response bundle between the router ports and the
// pheromone table controller.
//   master : drives i_req, i_op, i_dest, i_avail; observes the o_* results
//   slave  : the table controller side
// Port j of every [0:N-1] vector is router port j (0 = local).
interface ph_table_ctrl_if #(
  parameter int N     = 5,
  parameter int NODES = 16,
  parameter int PH_W  = 8
);
  localparam int DW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [0:N-1]                 i_req;
  logic [0:N-1]                 i_op;
  logic [0:N-1][DW-1:0]         i_dest;
  logic [0:N-1][0:N-2]          i_avail;
  logic [0:N-1]                 o_ack;
  logic [0:N-2][PH_W-1:0]       o_ph_values;
  logic [PW-1:0]                o_best_port;
  logic                         o_best_valid;
  logic                         o_busy;

  modport master (
    output i_req, i_op, i_dest, i_avail,
    input  o_ack, o_ph_values, o_best_port, o_best_valid, o_busy
  );

  modport slave (
    input  i_req, i_op, i_dest, i_avail,
    output o_ack, o_ph_values, o_best_port, o_best_valid, o_busy
  );
endinterface

// File: rtl/ph_table_ctrl.sv
// ph_table_ctrl: owns the per-router pheromone table (NODES rows x N-1
// columns) and serialises LOOKUP / UPDATE accesses from the N router ports
// with round-robin arbitration, one operation at a time.
// Column j of a row belongs to router port j+1.
//
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high reset (clears the table to PH_MIN)
//   bus    : ph_table_ctrl_if.slave (requests in, ack/results/busy out)
//
// Build option: define PH_EVAP_EN to add the periodic evaporation sweep
// (free-running timer, evap_pending flag and EVAP state). Without it the
// table only changes through UPDATE and EVAP_PERIOD has no effect.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting; evaporation first, else grant next requester (RR)
// EXEC  | one cycle: perform latched op, register results, ack next cycle
// EVAP  | sweep one row per cycle, decrementing every entry (PH_EVAP_EN)
module ph_table_ctrl #(
  parameter int N           = 5,
  parameter int NODES       = 16,
  parameter int PH_W        = 8,
  parameter int PH_MIN      = 0,
  parameter int PH_MAX      = 255,
  parameter int EVAP_PERIOD = 1024
) (
  input  logic          clk,
  input  logic          reset,
  ph_table_ctrl_if.slave bus
);
  localparam int DW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int C  = N - 1;
  localparam logic [PH_W-1:0] MIN_V = PH_W'(PH_MIN);
  localparam logic [PH_W-1:0] MAX_V = PH_W'(PH_MAX);

`ifdef PH_EVAP_EN
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_EVAP} state_t;
  localparam int TW = (EVAP_PERIOD > 1) ? $clog2(EVAP_PERIOD) : 1;
  logic [TW-1:0] timer_q;
  logic          evap_pending_q;
  logic [DW-1:0] row_q;
`else
  typedef enum logic [1:0] {S_IDLE, S_EXEC} state_t;
`endif

  state_t state_q, state_d;

  logic [PH_W-1:0]         tbl_q [NODES][C];
  logic [PW-1:0]           rr_q, win_q, gnt_idx, rr_nxt, cand;
  logic                    gnt_found, grant, op_q;
  logic [DW-1:0]           dest_q, row_sel;
  logic [0:C-1]            avail_q;
  logic                    in_range;
  logic [C-1:0]            arr;
  logic [PH_W-1:0]         cur_row [C];
  logic [PH_W-1:0]         upd_row [C];
  logic [PH_W-1:0]         best_val;
  logic                    best_found;
  logic [PW-1:0]           best_port;
  logic [0:N-1]            ack_q, ack_d;
  logic [0:C-1][PH_W-1:0]  ph_q;
  logic [PW-1:0]           best_port_q;
  logic                    best_valid_q;

  // Round-robin search starting at the pointer, wrapping modulo N.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = PW'((int'(rr_q) + k) % N);
      if (!gnt_found && bus.i_req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign rr_nxt = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + PW'(1);

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef PH_EVAP_EN
        if (evap_pending_q) state_d = S_EVAP;
        else
`endif
        if (gnt_found) begin
          grant   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_IDLE;
`ifdef PH_EVAP_EN
      S_EVAP: if (row_q == DW'(NODES - 1)) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Operation datapath for the latched request. Out-of-range rows read row 0
  // but are never written and their results are forced to zero.
  assign in_range = (int'(dest_q) < NODES);
  assign row_sel  = in_range ? dest_q : '0;

  always_comb begin
    best_found = 1'b0;
    best_val   = '0;
    best_port  = '0;
    arr        = '0;
    for (int j = 0; j < C; j++) begin
      // Column j is the arrival port's own column; local port 0 has none.
      arr[j]     = (win_q != '0) && (PW'(j + 1) == win_q);
      cur_row[j] = tbl_q[row_sel][j];
      if (arr[j])
        upd_row[j] = (cur_row[j] >= MAX_V) ? MAX_V : cur_row[j] + PH_W'(1);
      else
        upd_row[j] = (cur_row[j] <= MIN_V) ? MIN_V : cur_row[j] - PH_W'(1);
      // Strict '>' keeps the lowest column on ties.
      if (avail_q[j] && !arr[j] && (!best_found || cur_row[j] > best_val)) begin
        best_found = 1'b1;
        best_val   = cur_row[j];
        best_port  = PW'(j + 1);
      end
    end
  end

  always_comb begin
    ack_d = '0;
    if (state_q == S_EXEC) ack_d[win_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NODES; r++)
        for (int j = 0; j < C; j++)
          tbl_q[r][j] <= MIN_V;
    end else if (state_q == S_EXEC && op_q && in_range) begin
      for (int j = 0; j < C; j++)
        tbl_q[row_sel][j] <= upd_row[j];
    end
`ifdef PH_EVAP_EN
    else if (state_q == S_EVAP) begin
      for (int j = 0; j < C; j++)
        tbl_q[row_q][j] <= (tbl_q[row_q][j] <= MIN_V) ? MIN_V
                                                       : tbl_q[row_q][j] - PH_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      win_q        <= '0;
      op_q         <= 1'b0;
      dest_q       <= '0;
      avail_q      <= '0;
      ack_q        <= '0;
      ph_q         <= '0;
      best_port_q  <= '0;
      best_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      if (grant) begin
        win_q   <= gnt_idx;
        op_q    <= bus.i_op[gnt_idx];
        dest_q  <= bus.i_dest[gnt_idx];
        avail_q <= bus.i_avail[gnt_idx];
        rr_q    <= rr_nxt;
      end
      if (state_q == S_EXEC) begin
        if (!in_range) begin
          ph_q         <= '0;
          best_port_q  <= '0;
          best_valid_q <= 1'b0;
        end else if (op_q) begin
          for (int j = 0; j < C; j++) ph_q[j] <= upd_row[j];
          best_port_q  <= '0;
          best_valid_q <= 1'b0;
        end else begin
          for (int j = 0; j < C; j++) ph_q[j] <= cur_row[j];
          best_port_q  <= best_port;
          best_valid_q <= best_found;
        end
      end
    end
  end

`ifdef PH_EVAP_EN
  // Timer expiry wins over the clear, so an expiry is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q        <= '0;
      evap_pending_q <= 1'b0;
      row_q          <= '0;
    end else begin
      if (timer_q == TW'(EVAP_PERIOD - 1)) begin
        timer_q        <= '0;
        evap_pending_q <= 1'b1;
      end else begin
        timer_q <= timer_q + TW'(1);
        if (state_q == S_IDLE && evap_pending_q) evap_pending_q <= 1'b0;
      end
      if (state_q == S_IDLE && evap_pending_q) row_q <= '0;
      else if (state_q == S_EVAP)              row_q <= row_q + DW'(1);
    end
  end
`endif

  assign bus.o_ack        = ack_q;
  assign bus.o_ph_values  = ph_q;
  assign bus.o_best_port  = best_port_q;
  assign bus.o_best_valid = best_valid_q;
  assign bus.o_busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_ph_table_ctrl.sv
// Scoreboard bench for ph_table_ctrl: the driver issues requests and queues
// them per port; the monitor, on every ack, pops the request, updates a
// plain integer model of the table and compares the DUT results.
module tb_ph_table_ctrl;
  localparam int N      = 5;
  localparam int NODES  = 12;
  localparam int PH_W   = 8;
  localparam int PH_MIN = 1;
  localparam int PH_MAX = 6;
  localparam int EVAP_P = 60;
  localparam int DW     = 4;
  localparam int C      = N - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ph_table_ctrl_if #(.N(N), .NODES(NODES), .PH_W(PH_W)) bus ();

  ph_table_ctrl #(
    .N(N), .NODES(NODES), .PH_W(PH_W), .PH_MIN(PH_MIN), .PH_MAX(PH_MAX),
    .EVAP_PERIOD(EVAP_P)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    bit           op;
    int           dest;
    logic [0:C-1] avail;
    int           t_issue;
    bit           chk_lat;
  } req_t;

  req_t         pq [N][$];
  bit           active [N];
  bit [N-1:0]   req_hist [int];
  int           tbl [NODES][C];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           rr_m, sweeps_done, last_ack, busy_run;
  bit [N-1:0]   rv;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NODES; r++)
      for (int j = 0; j < C; j++) tbl[r][j] = PH_MIN;
    for (int p = 0; p < N; p++) pq[p].delete();
    req_hist.delete();
    rr_m        = 0;
    sweeps_done = 0;
    last_ack    = -100;
    busy_run    = 0;
  endtask

  task automatic handle_ack();
    int p, n, g, w, bv, bp, bval;
    int ev [C];
    req_t r;
    n = 0;
    p = -1;
    for (int i = 0; i < N; i++)
      if (bus.o_ack[i]) begin
        n++;
        if (p < 0) p = i;
      end
    chk("ack_onehot", n, 1);
    chk("ack_spacing_ge2", (cyc - last_ack >= 2) ? 1 : 0, 1);
    last_ack = cyc;
    g = cyc - 1;  // grant happened one edge before the ack edge
`ifdef PH_EVAP_EN
    // A sweep requested at edge k*EVAP_P runs before any op granted later.
    while ((sweeps_done + 1) * EVAP_P < g) begin
      for (int rr = 0; rr < NODES; rr++)
        for (int j = 0; j < C; j++)
          tbl[rr][j] = (tbl[rr][j] - 1 < PH_MIN) ? PH_MIN : tbl[rr][j] - 1;
      sweeps_done++;
    end
`endif
    w = -1;
    if (req_hist.exists(g))
      for (int k = 0; k < N; k++)
        if (w < 0 && req_hist[g][(rr_m + k) % N]) w = (rr_m + k) % N;
    chk("rr_winner", p, w);
    rr_m = (p + 1) % N;
    if (pq[p].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious_ack: port %0d acked with no request outstanding", p);
      return;
    end
    r = pq[p].pop_front();
    if (r.chk_lat) chk("req_to_ack_latency", cyc - r.t_issue, 2);
    bv = 0; bp = 0; bval = -1;
    for (int j = 0; j < C; j++) ev[j] = 0;
    if (r.dest < NODES) begin
      for (int j = 0; j < C; j++) begin
        if (r.op) begin
          if (j == p - 1) tbl[r.dest][j] = (tbl[r.dest][j] + 1 > PH_MAX) ? PH_MAX : tbl[r.dest][j] + 1;
          else            tbl[r.dest][j] = (tbl[r.dest][j] - 1 < PH_MIN) ? PH_MIN : tbl[r.dest][j] - 1;
        end else if (r.avail[j] && j != p - 1 && tbl[r.dest][j] > bval) begin
          bval = tbl[r.dest][j];
          bp   = j + 1;
          bv   = 1;
        end
        ev[j] = tbl[r.dest][j];
      end
    end
    for (int j = 0; j < C; j++)
      chk($sformatf("ph_col%0d port%0d dest%0d op%0d", j, p, r.dest, r.op),
          int'(bus.o_ph_values[j]), ev[j]);
    chk("best_valid", int'(bus.o_best_valid), bv);
    if (!r.op) chk("best_port", int'(bus.o_best_port), bp);
  endtask

  // Monitor
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) begin
        model_reset();
      end else begin
        for (int p = 0; p < N; p++) rv[p] = bus.i_req[p];
        req_hist[cyc + 1] = rv;
        if (bus.o_busy) busy_run++;
        else if (busy_run > 0) begin
`ifdef PH_EVAP_EN
          chk("busy_run_len", busy_run, (busy_run > 1) ? NODES : 1);
`else
          chk("busy_run_len", busy_run, 1);
`endif
          busy_run = 0;
        end
        if (bus.o_ack != '0) handle_ack();
      end
    end
  end

  // Driver
  task automatic step();
    @(posedge clk);
    #2;
    for (int p = 0; p < N; p++)
      if (active[p] && bus.o_ack[p]) begin
        active[p]     = 1'b0;
        bus.i_req[p]  = 1'b0;
      end
  endtask

  task automatic issue(input int p, input bit op, input int dest,
                       input logic [0:C-1] av, input bit lat);
    req_t r;
    bus.i_req[p]   = 1'b1;
    bus.i_op[p]    = op;
    bus.i_dest[p]  = DW'(dest);
    bus.i_avail[p] = av;
    active[p]      = 1'b1;
    r.op = op; r.dest = dest; r.avail = av; r.t_issue = cyc; r.chk_lat = lat;
    pq[p].push_back(r);
  endtask

  function automatic bit any_active();
    for (int p = 0; p < N; p++) if (active[p]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (any_active() && t < budget) begin
      step();
      t++;
    end
    if (any_active()) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: requests still pending after %0d cycles", budget);
    end
  endtask

  initial begin
    int t;
    logic [0:C-1] all_av;
    all_av = '1;
    bus.i_req = '0; bus.i_op = '0; bus.i_dest = '0; bus.i_avail = '0;
    for (int p = 0; p < N; p++) active[p] = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", int'(bus.o_ack), 0);
    for (int j = 0; j < C; j++) chk($sformatf("rst_ph%0d", j), int'(bus.o_ph_values[j]), 0);
    chk("rst_best_port", int'(bus.o_best_port), 0);
    chk("rst_best_valid", int'(bus.o_best_valid), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    #1 reset = 1'b0;

    // LOOKUP from port 1 on a fresh table, uncontended latency
    step();
    issue(1, 1'b0, 3, all_av, 1'b1);
    wait_idle(50);

    // Three reinforcements of row 5 from port 2, then a lookup from port 1
    for (int k = 0; k < 3; k++) begin
      step();
      issue(2, 1'b1, 5, all_av, 1'b1);
      wait_idle(50);
    end
    step();
    issue(1, 1'b0, 5, all_av, 1'b0);
    wait_idle(50);

    // Ceiling saturation from port 4 on row 0
    for (int k = 0; k < 7; k++) begin
      step();
      issue(4, 1'b1, 0, all_av, 1'b0);
      wait_idle(50);
    end
    step();
    issue(0, 1'b0, 0, all_av, 1'b0);
    wait_idle(50);

    // Random traffic across many evaporation periods
    for (int k = 0; k < 2500; k++) begin
      step();
      for (int p = 0; p < N; p++)
        if (!active[p] && $urandom_range(0, 2) == 0)
          issue(p, 1'(($urandom_range(0, 1))), $urandom_range(0, 15), C'($urandom), 1'b0);
    end
    wait_idle(300);

    // Reset during the EXEC of an UPDATE, placed clear of any sweep
    t = 0;
    while ((cyc % EVAP_P) != 30 && t < 200) begin
      step();
      t++;
    end
    issue(2, 1'b1, 7, all_av, 1'b0);
    step();
    #1 reset = 1'b1;
    bus.i_req = '0;
    for (int p = 0; p < N; p++) active[p] = 1'b0;
    @(negedge clk);
    chk("abort_ack", int'(bus.o_ack), 0);
    for (int j = 0; j < C; j++) chk($sformatf("abort_ph%0d", j), int'(bus.o_ph_values[j]), 0);
    chk("abort_best_port", int'(bus.o_best_port), 0);
    chk("abort_best_valid", int'(bus.o_best_valid), 0);
    chk("abort_busy", int'(bus.o_busy), 0);
    @(negedge clk);
    #1 reset = 1'b0;

    // All ports held after reset: RR from 0, table read back at PH_MIN
    step();
    for (int p = 0; p < N; p++) issue(p, 1'b0, (p == 2) ? 7 : p, all_av, 1'b0);
    for (int k = 0; k < 40; k++) begin
      step();
      for (int p = 0; p < N; p++)
        if (!active[p]) issue(p, 1'b0, $urandom_range(0, NODES - 1), C'($urandom), 1'b0);
    end
    wait_idle(100);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end
endmodule
